// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// The starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

    // Which requester owns the memory response that arrives next cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive denied fetch cycles and flags when fetch must be forced.
// Instantiated by mem_arbiter only when ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req_valid,
    input  logic if_grant,
    output logic starve
);

    localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

    logic [3:0] count;

    // A withdrawn fetch also clears the count: starvation is per pending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (!if_req_valid || if_grant) begin
            count <= 4'd0;
        end else if (count != LIMIT) begin
            count <= count + 4'd1;
        end
    end

    assign starve = (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single-port synchronous memory.
// Data has priority; define ARB_STARVE_GUARD_EN to force periodic fetch grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_we,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output arb_state_t          arb_state
);

    // Handshake: a request transfers in a cycle where valid and ready are both
    // high; ready is never raised without valid, and valid may be dropped
    // before acceptance with no effect. Responses have no backpressure.

    logic       if_grant;
    logic       d_grant;
    logic       starve_force;
    arb_state_t state;
    arb_state_t next_state;
    logic       resp_store;
    logic       next_store;

`ifdef ARB_STARVE_GUARD_EN
    mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_grant     (if_grant),
        .starve       (starve_force)
    );
`else
    assign starve_force = 1'b0;
`endif

    // Grants are gated by rst so nothing is accepted while reset is held.
    assign if_grant = ~rst & if_req_valid & (~d_req_valid | starve_force);
    assign d_grant  = ~rst & d_req_valid & ~if_grant;

    assign if_req_ready = if_grant;
    assign d_req_ready  = d_grant;

    assign mem_en    = if_grant | d_grant;
    assign mem_we    = d_grant & d_we;
    assign mem_addr  = if_grant ? if_addr : d_addr;
    assign mem_wdata = d_wdata;
    assign mem_be    = d_grant ? d_be : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            resp_store <= 1'b0;
        end else begin
            state      <= next_state;
            resp_store <= next_store;
        end
    end

    always_comb begin
        next_state   = IDLE;
        next_store   = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_data   = '0;

        if (if_grant) begin
            next_state = RESP_IF;
        end else if (d_grant) begin
            next_state = RESP_D;
            next_store = d_we;
        end

        case (state)
            RESP_IF: begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = mem_rdata;
            end
            RESP_D: begin
                d_rsp_valid = 1'b1;
                d_rsp_data  = resp_store ? '0 : mem_rdata;
            end
            default: ;
        endcase
    end

    assign arb_state = state;

endmodule
